srl_fifo_ctrl: RTL and testbench
================================

# srl_fifo_ctrl

Synchronous FIFO controller that sequences a vectorized SRL shift-register datapath (`srlvec`) as a shallow, LUT-dense FIFO. It owns the occupancy counter, the SRL shift-enable and the read address, and presents valid/ready handshakes on both sides. It is used wherever a short elastic buffer (16 or 32 entries) is needed without spending block RAM or flop arrays.

## Interface
Parameters:
- `NBITS`, 8, data width.
- `USE_SRL16`, "TRUE", selects the SRL primitive. "TRUE" gives SRL16 with DEPTH=16 and ADDR_BITS=4; anything else gives SRL32 with DEPTH=32 and ADDR_BITS=5.

Ports:
- `clk`, in, 1, the single clock.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `s_data`, in, NBITS, write data.
- `s_valid`, in, 1, write request.
- `s_ready`, out, 1, space available.
- `m_data`, out, NBITS, head-of-FIFO data.
- `m_valid`, out, 1, head data valid.
- `m_ready`, in, 1, consumer accepts the head.
- `count`, out, ADDR_BITS+1, total entries held (0..capacity).
- `full`, out, 1, count == capacity.
- `empty`, out, 1, count == 0.

## Operation
- The SRL ce is asserted as `push = s_valid & s_ready`. `s_data` drives SRL `din`.
- In the SRL, the newest entry sits at address 0 and the oldest at address `ptr`.
- The controller keeps a registered `ptr` (ADDR_BITS bits) and a registered SRL occupancy `occ`.
- Pointer and occupancy update rules:
  - Push only, occ 0 to 1: `ptr` stays 0.
  - Push only, occ ≥ 1: `ptr` increments by 1.
  - Pop only, occ ≥ 2: `ptr` decrements by 1.
  - Pop only, occ 1 to 0: `ptr` stays 0.
  - Push and pop together: `ptr` and `occ` are unchanged, because the shift moves the head up one slot while the pop removes it.
- A pop is defined as `m_valid & m_ready`.
- `s_ready = ~full`. It depends only on registered state, so there is no combinational path from `m_ready`.
- A push while full is impossible, since `s_ready` is 0.
- A pop while empty is impossible, since `m_valid` is 0.
- A simultaneous push and pop while full is not possible: `s_ready` is low, so only the pop occurs.
- There is no wrap-around: `ptr` never exceeds DEPTH-1 and never goes below 0.
- SRL contents are not reset; only control state is.
- Reset values: `occ`=0, `ptr`=0, `count`=0, `empty`=1, `full`=0, `s_ready`=1 (after reset release), `m_valid`=0.
- `m_data` is unspecified while `m_valid`=0.
- An assertion of `rst_n` mid-stream discards all entries asynchronously. The first push after release is the new head.

## Timing
- Without the output register, the SRL read is combinational from `ptr`:
  - `m_valid = (occ != 0)`.
  - `m_data` = SRL dout.
  - A push at edge N gives `m_valid`=1 after edge N, so first-word latency is 1 cycle.
  - Capacity is DEPTH.
- `count`, `full` and `empty` are registered and are valid in the cycle after the causing edge.
- Sustained throughput is 1 word per cycle when `m_ready`=1, including while full: a pop at edge N raises `s_ready` after edge N.

## Configuration
- Macro `SRL_FIFO_OUTREG_EN` is undefined by default.
- When the macro is undefined, behaviour is exactly as above.
- When the macro is defined, a one-entry output register follows the SRL:
  - `m_data` and `m_valid` come directly from flops.
  - The register loads from the SRL head when the SRL is non-empty and (the register is empty or `m_ready`=1). That load is an internal SRL pop.
  - First-word latency becomes 2 cycles.
  - Capacity becomes DEPTH+1, and `count` includes the register.
  - `full` is asserted only when the SRL and the register are both full.
  - Throughput remains 1 word per cycle.
  - The register valid bit resets to 0.

## Structure
- Shared package `srl_pkg` holds:
  - A constant function `srl_depth(use_srl16)` returning 16 or 32.
  - A constant function `srl_addr_bits(use_srl16)` returning 4 or 5.
- Exactly one sub-module is instantiated: the existing `srlvec` datapath, connected with `.ce(push)`, `.a(ptr)`, `.din(s_data)` and `.dout` to the head data.
- All control logic is local to `srl_fifo_ctrl`.

## Test plan
- Reset then idle: with `rst_n` low for 3 cycles, then high for 5 cycles, the bench sees `m_valid`=0, `empty`=1, `count`=0 and `s_ready`=1 throughout.
- Fill and drain, SRL16, NBITS=8, no macro: push 0x00..0x0F back-to-back with `m_ready`=0. `full` goes to 1 after the 16th edge and `s_ready` goes to 0. Then `m_ready`=1 drains 0x00..0x0F in order, one per cycle, ending with `empty`=1.
- Simultaneous push and pop at occ=5 (entries 0xA0..0xA4): push 0xB0 with `m_ready`=1 for 1 cycle. `count` stays 5 and the head becomes 0xA1. Draining then gives 0xA1..0xA4 followed by 0xB0.
- Full with pop: at `full`, holding `s_valid`=1 and `m_ready`=1 for 20 cycles gives an output of exactly 1 word per cycle, in order, with no loss or duplication. `s_ready` toggles only from the full state.
- Reset mid-operation: with `count`=7, pulse `rst_n` low asynchronously, away from any clock edge. `m_valid` drops immediately and `count`=0. The next push of 0x55 appears on `m_data` as the head one cycle later.
- With `SRL_FIFO_OUTREG_EN` defined and USE_SRL16="FALSE": push 33 words 0x00..0x20 with `m_ready`=0. `full` is asserted after the 33rd. The first `m_valid` occurs 2 cycles after the first push, and the drain order is 0x00..0x20.

Source files
------------

// File: rtl/srl_pkg.sv
// Shared sizing helpers for the SRL-based FIFO: depth and address width for the SRL16/SRL32
// primitives.
package srl_pkg;

    function automatic int unsigned srl_depth(input bit use_srl16);
        return use_srl16 ? 32'd16 : 32'd32;
    endfunction

    function automatic int unsigned srl_addr_bits(input bit use_srl16);
        return use_srl16 ? 32'd4 : 32'd5;
    endfunction

endpackage

// File: rtl/srlvec.sv
// Vectorized SRL datapath: NBITS parallel shift registers sharing one shift enable and one
// read address. Newest entry at address 0. Contents are never reset.
module srlvec
    import srl_pkg::*;
#(
    parameter int unsigned NBITS     = 8,
    parameter              USE_SRL16 = "TRUE"
) (
    input  logic                                               clk,
    input  logic                                               ce,
    input  logic [srl_addr_bits(USE_SRL16 == "TRUE")-1:0]      a,
    input  logic [NBITS-1:0]                                   din,
    output logic [NBITS-1:0]                                   dout
);

    localparam int unsigned DEPTH = srl_depth(USE_SRL16 == "TRUE");

    logic [NBITS-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[a];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Shallow FIFO built on an SRL vector; owns occupancy, shift enable and read address.
// Define SRL_FIFO_OUTREG_EN to add a one-entry output register after the SRL.
module srl_fifo_ctrl
    import srl_pkg::*;
#(
    parameter int unsigned NBITS     = 8,
    parameter              USE_SRL16 = "TRUE"
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NBITS-1:0]                              s_data,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    output logic [NBITS-1:0]                              m_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [srl_addr_bits(USE_SRL16 == "TRUE"):0]   count,
    output logic                                          full,
    output logic                                          empty
);

    localparam bit          IS16  = (USE_SRL16 == "TRUE");
    localparam int unsigned DEPTH = srl_depth(IS16);
    localparam int unsigned AB    = srl_addr_bits(IS16);
`ifdef SRL_FIFO_OUTREG_EN
    localparam int unsigned CAP   = DEPTH + 1;
`else
    localparam int unsigned CAP   = DEPTH;
`endif
    localparam logic [AB:0] CAPV  = (AB+1)'(CAP);
    localparam logic [AB:0] ONE   = {{AB{1'b0}}, 1'b1};

    logic [AB-1:0]    ptr_q, ptr_d;
    logic [AB:0]      occ_q, occ_d;
    logic [AB:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             push, srl_pop, srl_nempty;
    logic [NBITS-1:0] srl_dout;

    assign s_ready    = ~full_q;
    assign push       = s_valid & s_ready;
    assign srl_nempty = (occ_q != '0);

    srlvec #(
        .NBITS     (NBITS),
        .USE_SRL16 (USE_SRL16)
    ) u_srlvec (
        .clk  (clk),
        .ce   (push),
        .a    (ptr_q),
        .din  (s_data),
        .dout (srl_dout)
    );

`ifdef SRL_FIFO_OUTREG_EN
    logic             rv_q, rv_d;
    logic [NBITS-1:0] rd_q;

    // Loading the register is an internal SRL pop.
    assign srl_pop = srl_nempty & (~rv_q | m_ready);

    always_comb begin
        rv_d = rv_q;
        if (srl_pop) begin
            rv_d = 1'b1;
        end else if (m_ready) begin
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q <= 1'b0;
        end else begin
            rv_q <= rv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (srl_pop) begin
            rd_q <= srl_dout;
        end
    end

    assign m_valid = rv_q;
    assign m_data  = rd_q;
    assign count_d = occ_d + {{AB{1'b0}}, rv_d};
`else
    assign srl_pop = srl_nempty & m_ready;
    assign m_valid = srl_nempty;
    assign m_data  = srl_dout;
    assign count_d = occ_d;
`endif

    // Push+pop leaves ptr/occ alone: the shift moves the next entry into the head slot.
    always_comb begin
        ptr_d = ptr_q;
        occ_d = occ_q;
        if (push && !srl_pop) begin
            occ_d = occ_q + ONE;
            if (srl_nempty) begin
                ptr_d = ptr_q + 1'b1;
            end
        end else if (!push && srl_pop) begin
            occ_d = occ_q - ONE;
            if (occ_q > ONE) begin
                ptr_d = ptr_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            occ_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            count_q <= count_d;
            full_q  <= (count_d == CAPV);
            empty_q <= (count_d == '0);
        end
    end

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Self-checking bench for srl_fifo_ctrl against a queue-level FIFO model.
// Honours SRL_FIFO_OUTREG_EN (then exercises the SRL32 build).
module tb_srl_fifo_ctrl;

`ifdef SRL_FIFO_OUTREG_EN
    localparam     USE  = "FALSE";
    localparam int CAP  = 33;
    localparam int CW   = 6;
    localparam bit OREG = 1'b1;
`else
    localparam     USE  = "TRUE";
    localparam int CAP  = 16;
    localparam int CW   = 5;
    localparam bit OREG = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    srl_fifo_ctrl #(
        .NBITS     (8),
        .USE_SRL16 (USE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mq holds everything in the FIFO (plain build) or only the SRL part (output-register
    // build, where rv/rd model the output stage).
    logic [7:0] mq[$];
    bit         rv;
    logic [7:0] rd;

    function automatic int exp_count();
        return mq.size() + (OREG ? int'(rv) : 0);
    endfunction

    function automatic bit exp_mvalid();
        return OREG ? rv : (mq.size() != 0);
    endfunction

    function automatic logic [7:0] exp_mdata();
        return OREG ? rd : mq[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count",   32'(count),   32'(exp_count()));
        chk("empty",   32'(empty),   32'(exp_count() == 0));
        chk("full",    32'(full),    32'(exp_count() == CAP));
        chk("s_ready", 32'(s_ready), 32'(exp_count() != CAP));
        chk("m_valid", 32'(m_valid), 32'(exp_mvalid()));
        if (exp_mvalid()) chk("m_data", 32'(m_data), 32'(exp_mdata()));
    endtask

    // Drive one cycle: inputs set just after a negedge, outputs checked, model advanced.
    task automatic step(input bit sv, input logic [7:0] sd, input bit mr);
        bit push, load, pop;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        check_outputs();
        push = sv && (exp_count() != CAP);
        if (OREG) begin
            load = (mq.size() != 0) && (!rv || mr);
            if (load) begin
                rd = mq.pop_front();
                rv = 1'b1;
            end else if (mr) begin
                rv = 1'b0;
            end
        end else begin
            pop = (mq.size() != 0) && mr;
            if (pop) void'(mq.pop_front());
        end
        if (push) mq.push_back(sd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        int first_valid;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        rv      = 1'b0;
        rd      = 8'h00;

        // Reset held for 3 cycles, then idle for 5.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_outputs();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);

        // Fill to capacity with consumer stalled; record first-word latency.
        first_valid = -1;
        for (int i = 0; i < CAP; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (m_valid && first_valid < 0) first_valid = i + 1;
        end
        chk("first_word_latency", 32'(first_valid), OREG ? 32'd2 : 32'd1);
        step(1'b1, 8'hEE, 1'b0);          // rejected while full
        drain(CAP + 2);

        // Simultaneous push and pop with five entries held.
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        step(1'b1, 8'hB0, 1'b1);
        drain(8);

        // Full, then push and pop held together for 20 cycles.
        for (int i = 0; i < CAP; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1);
        drain(CAP + 2);

        // Asynchronous reset mid-stream, away from clock edges.
        for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        rv = 1'b0;
        chk("async_rst_m_valid", 32'(m_valid), 32'd0);
        chk("async_rst_count",   32'(count),   32'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        drain(3);

        // Random traffic: producer-heavy then consumer-heavy.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 1) != 0), 8'($urandom), ($urandom_range(0, 1) != 0));
        drain(CAP + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
